panda_risc_v_dbus_icb_arbiter: RTL and testbench
================================================

# panda_risc_v_dbus_icb_arbiter

Two-to-one ICB arbiter that shares one data-bus ICB master port between the EXU load/store unit (requester 0) and a second data-bus requester (requester 1, e.g. debug or DMA). It sits between the execution unit's data ICB master and the system data bus. Command handshakes are arbitrated round-robin with grant lock while a command stalls. Every accepted command's source ID is recorded in an in-order outstanding FIFO, which routes each response back to the requester that issued it.

## Interface
Parameters:
- outstanding_depth, 4, outstanding-command FIFO depth; power of two, 2..16
- simulation_delay, 1, register update delay for simulation

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- s0_icb_cmd_addr/read/wdata/wmask  input  32/1/32/4  requester 0 command payload
- s0_icb_cmd_valid  input  1; s0_icb_cmd_ready  output  1
- s0_icb_rsp_rdata/err  output  32/1  requester 0 response payload
- s0_icb_rsp_valid  output  1; s0_icb_rsp_ready  input  1
- s1_icb_*  same set as s0, requester 1
- m_icb_cmd_addr/read/wdata/wmask  output  32/1/32/4  arbitrated command payload
- m_icb_cmd_valid  output  1; m_icb_cmd_ready  input  1
- m_icb_rsp_rdata/err  input  32/1; m_icb_rsp_valid  input  1; m_icb_rsp_ready  output  1
- outstanding_cnt  output  5  number of commands accepted but not yet responded
- rsp_orphan  output  1  one-cycle pulse: response received with FIFO empty

## Operation
- Registered state: rr_last (last granted source), lock_vld + lock_id, outstanding FIFO (ID bits, wr/rd pointers with wrap bit), orphan pulse register.
- Eligible source: valid asserted and FIFO not full. A full FIFO blocks all commands, including in a cycle that also pops.
- Grant selection, in order: if lock_vld, grant lock_id; else if only one source is valid, grant that source; else, with both valid, grant the source != rr_last.
- m_icb_cmd_* = payload of the granted source. m_icb_cmd_valid = granted valid & !full. Granted sX_icb_cmd_ready = m_icb_cmd_ready & !full. The non-granted ready = 0.
- Command handshake (m valid & ready): push granted ID, rr_last <= granted ID, lock_vld <= 0.
- Granted valid with m_icb_cmd_ready = 0: lock_vld <= 1, lock_id <= granted ID. The payload must stay stable under ICB rules, so the grant cannot switch mid-command.
- Response routing: head ID selects the destination. sHEAD_icb_rsp_valid = m_icb_rsp_valid & !empty. Payload is broadcast to both requesters. The other rsp_valid = 0. m_icb_rsp_ready = sHEAD rsp_ready when not empty.
- Response handshake: pop.
- Orphan response (m_icb_rsp_valid with FIFO empty): m_icb_rsp_ready = 1, response dropped, rsp_orphan = 1 next cycle.
- Same-cycle push and pop: both happen; outstanding_cnt is unchanged.
- outstanding_cnt = wr_ptr - rd_ptr, using 5-bit pointer difference with wrap.

## Timing
- Command and response paths are combinational pass-through: zero added latency. Grant/lock/FIFO state updates on the rising clk edge.
- Reset values: FIFO empty, outstanding_cnt = 0, rr_last = 1 (s0 wins the first tie), lock_vld = 0, rsp_orphan = 0.
- While resetn = 0, all valid/ready outputs = 0.
- A reset asserted mid-transfer discards outstanding IDs; the bus must be reset together with this block.
- Back-to-back commands from one source: one per cycle while FIFO not full.
- Full FIFO: cmd_ready drops in the same cycle cnt reaches outstanding_depth. It rises again in the cycle after a pop.

## Configuration
- PANDA_DBUS_ARB_FIXED_PRIO_EN defined: the tie rule becomes fixed priority, with s0 (LSU) always winning when both are valid and not locked. rr_last is not implemented.
- Undefined (default): round-robin as in Operation.
- Lock and outstanding behaviour are identical in both builds.

## Test plan
- Both valid every cycle, m ready = 1, slave responds 1 cycle later -> grants alternate s0,s1,s0,s1. Each response (rdata = addr) arrives at the issuing source only.
- s1 valid with m_icb_cmd_ready = 0 for 3 cycles while s0 raises valid in cycle 2 -> m payload stays s1's for all 3 cycles. s0 is granted on the cycle after the s1 handshake.
- depth 4: 4 s0 commands accepted with no response -> outstanding_cnt = 4, cmd_ready = 0 on the 5th. Respond once -> cnt = 3, 5th command accepted the next cycle.
- Head = s0 with s0_icb_rsp_ready = 0 for 2 cycles -> m_icb_rsp_ready = 0, s1 rsp_valid = 0. Pop only when s0 ready = 1.
- m_icb_rsp_valid = 1 with FIFO empty -> m_icb_rsp_ready = 1, no sX rsp_valid, rsp_orphan = 1 for exactly one cycle.
- resetn pulled low with 3 outstanding -> outstanding_cnt = 0, all valid/ready = 0. After release, the first tie goes to s0.

Source files
------------

// File: rtl/panda_risc_v_dbus_icb_arbiter.sv
// Two-to-one data-bus ICB arbiter: round-robin command grant with stall lock, in-order response routing.
// Define PANDA_DBUS_ARB_FIXED_PRIO_EN to replace the round-robin tie rule with fixed priority to s0.
module panda_risc_v_dbus_icb_arbiter #(
   parameter int outstanding_depth = 4,
   parameter int simulation_delay  = 1
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic [31:0] s0_icb_cmd_addr,
   input  logic        s0_icb_cmd_read,
   input  logic [31:0] s0_icb_cmd_wdata,
   input  logic [3:0]  s0_icb_cmd_wmask,
   input  logic        s0_icb_cmd_valid,
   output logic        s0_icb_cmd_ready,
   output logic [31:0] s0_icb_rsp_rdata,
   output logic        s0_icb_rsp_err,
   output logic        s0_icb_rsp_valid,
   input  logic        s0_icb_rsp_ready,

   input  logic [31:0] s1_icb_cmd_addr,
   input  logic        s1_icb_cmd_read,
   input  logic [31:0] s1_icb_cmd_wdata,
   input  logic [3:0]  s1_icb_cmd_wmask,
   input  logic        s1_icb_cmd_valid,
   output logic        s1_icb_cmd_ready,
   output logic [31:0] s1_icb_rsp_rdata,
   output logic        s1_icb_rsp_err,
   output logic        s1_icb_rsp_valid,
   input  logic        s1_icb_rsp_ready,

   output logic [31:0] m_icb_cmd_addr,
   output logic        m_icb_cmd_read,
   output logic [31:0] m_icb_cmd_wdata,
   output logic [3:0]  m_icb_cmd_wmask,
   output logic        m_icb_cmd_valid,
   input  logic        m_icb_cmd_ready,
   input  logic [31:0] m_icb_rsp_rdata,
   input  logic        m_icb_rsp_err,
   input  logic        m_icb_rsp_valid,
   output logic        m_icb_rsp_ready,

   output logic [4:0]  outstanding_cnt,
   output logic        rsp_orphan
);

   localparam int AW = $clog2(outstanding_depth);
   localparam int PW = AW + 1;

   // The simulation delay parameter is accepted for interface compatibility; no delay is modelled here.
   logic sim_delay_unused;
   assign sim_delay_unused = (simulation_delay != 0);

   logic          lock_vld_q, lock_vld_d;
   logic          lock_id_q, lock_id_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          orphan_q, orphan_d;
   logic          id_mem_q [outstanding_depth];

   logic          tie_id;
   logic          grant_id;
   logic          grant_valid;
   logic          cmd_present;
   logic          push;
   logic          pop;
   logic [PW-1:0] ptr_diff;
   logic          fifo_full;
   logic          fifo_empty;
   logic          head_id;
   logic          head_rsp_ready;

   assign ptr_diff   = wr_ptr_q - rd_ptr_q;
   assign fifo_full  = (ptr_diff == PW'(outstanding_depth));
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);

`ifdef PANDA_DBUS_ARB_FIXED_PRIO_EN
   assign tie_id = 1'b0;
`else
   logic rr_last_q, rr_last_d;

   assign rr_last_d = push ? grant_id : rr_last_q;
   assign tie_id    = ~rr_last_q;

   // Reset to s1 so that s0 wins the first tie.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rr_last_q <= 1'b1;
      else         rr_last_q <= rr_last_d;
   end
`endif

   // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      grant_id = 1'b0;
      if (lock_vld_q)                               grant_id = lock_id_q;
      else if (s0_icb_cmd_valid && !s1_icb_cmd_valid) grant_id = 1'b0;
      else if (s1_icb_cmd_valid && !s0_icb_cmd_valid) grant_id = 1'b1;
      else if (s0_icb_cmd_valid && s1_icb_cmd_valid)  grant_id = tie_id;
   end

   assign grant_valid = grant_id ? s1_icb_cmd_valid : s0_icb_cmd_valid;
   assign cmd_present = grant_valid & ~fifo_full;
   assign push        = resetn & cmd_present & m_icb_cmd_ready;

   assign m_icb_cmd_addr   = grant_id ? s1_icb_cmd_addr  : s0_icb_cmd_addr;
   assign m_icb_cmd_read   = grant_id ? s1_icb_cmd_read  : s0_icb_cmd_read;
   assign m_icb_cmd_wdata  = grant_id ? s1_icb_cmd_wdata : s0_icb_cmd_wdata;
   assign m_icb_cmd_wmask  = grant_id ? s1_icb_cmd_wmask : s0_icb_cmd_wmask;
   assign m_icb_cmd_valid  = resetn & cmd_present;
   assign s0_icb_cmd_ready = resetn & ~grant_id & m_icb_cmd_ready & ~fifo_full;
   assign s1_icb_cmd_ready = resetn &  grant_id & m_icb_cmd_ready & ~fifo_full;

   // A presented but stalled command pins the grant so its payload stays stable until accepted.
   always_comb begin
      lock_vld_d = lock_vld_q;
      lock_id_d  = lock_id_q;
      if (push) begin
         lock_vld_d = 1'b0;
      end else if (cmd_present) begin
         lock_vld_d = 1'b1;
         lock_id_d  = grant_id;
      end else if (!grant_valid) begin
         lock_vld_d = 1'b0;
      end
   end

   assign head_id        = id_mem_q[rd_ptr_q[AW-1:0]];
   assign head_rsp_ready = head_id ? s1_icb_rsp_ready : s0_icb_rsp_ready;

   assign m_icb_rsp_ready  = resetn & (fifo_empty | head_rsp_ready);
   assign s0_icb_rsp_valid = resetn & m_icb_rsp_valid & ~fifo_empty & ~head_id;
   assign s1_icb_rsp_valid = resetn & m_icb_rsp_valid & ~fifo_empty &  head_id;
   assign s0_icb_rsp_rdata = m_icb_rsp_rdata;
   assign s1_icb_rsp_rdata = m_icb_rsp_rdata;
   assign s0_icb_rsp_err   = m_icb_rsp_err;
   assign s1_icb_rsp_err   = m_icb_rsp_err;

   assign pop      = resetn & m_icb_rsp_valid & ~fifo_empty & head_rsp_ready;
   assign orphan_d = m_icb_rsp_valid & fifo_empty;
   assign wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
   assign rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

   // NOTE: sequential state is updated with non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_vld_q <= 1'b0;
         lock_id_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         orphan_q   <= 1'b0;
      end else begin
         lock_vld_q <= lock_vld_d;
         lock_id_q  <= lock_id_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         orphan_q   <= orphan_d;
      end
   end

   // NOTE: the ID storage has no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) id_mem_q[wr_ptr_q[AW-1:0]] <= grant_id;
   end

   assign outstanding_cnt = 5'(ptr_diff);
   assign rsp_orphan      = orphan_q;

endmodule

// File: tb/tb_panda_risc_v_dbus_icb_arbiter.sv
// Self-checking bench for panda_risc_v_dbus_icb_arbiter: cycle table with response scoreboard plus corner-case sequences.
module tb_panda_risc_v_dbus_icb_arbiter;

   logic        clk;
   logic        resetn;
   logic [31:0] s0_icb_cmd_addr, s1_icb_cmd_addr, m_icb_cmd_addr;
   logic        s0_icb_cmd_read, s1_icb_cmd_read, m_icb_cmd_read;
   logic [31:0] s0_icb_cmd_wdata, s1_icb_cmd_wdata, m_icb_cmd_wdata;
   logic [3:0]  s0_icb_cmd_wmask, s1_icb_cmd_wmask, m_icb_cmd_wmask;
   logic        s0_icb_cmd_valid, s1_icb_cmd_valid, m_icb_cmd_valid;
   logic        s0_icb_cmd_ready, s1_icb_cmd_ready, m_icb_cmd_ready;
   logic [31:0] s0_icb_rsp_rdata, s1_icb_rsp_rdata, m_icb_rsp_rdata;
   logic        s0_icb_rsp_err, s1_icb_rsp_err, m_icb_rsp_err;
   logic        s0_icb_rsp_valid, s1_icb_rsp_valid, m_icb_rsp_valid;
   logic        s0_icb_rsp_ready, s1_icb_rsp_ready, m_icb_rsp_ready;
   logic [4:0]  outstanding_cnt;
   logic        rsp_orphan;

   panda_risc_v_dbus_icb_arbiter #(
      .outstanding_depth(4),
      .simulation_delay (1)
   ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .s0_icb_cmd_addr  (s0_icb_cmd_addr),
      .s0_icb_cmd_read  (s0_icb_cmd_read),
      .s0_icb_cmd_wdata (s0_icb_cmd_wdata),
      .s0_icb_cmd_wmask (s0_icb_cmd_wmask),
      .s0_icb_cmd_valid (s0_icb_cmd_valid),
      .s0_icb_cmd_ready (s0_icb_cmd_ready),
      .s0_icb_rsp_rdata (s0_icb_rsp_rdata),
      .s0_icb_rsp_err   (s0_icb_rsp_err),
      .s0_icb_rsp_valid (s0_icb_rsp_valid),
      .s0_icb_rsp_ready (s0_icb_rsp_ready),
      .s1_icb_cmd_addr  (s1_icb_cmd_addr),
      .s1_icb_cmd_read  (s1_icb_cmd_read),
      .s1_icb_cmd_wdata (s1_icb_cmd_wdata),
      .s1_icb_cmd_wmask (s1_icb_cmd_wmask),
      .s1_icb_cmd_valid (s1_icb_cmd_valid),
      .s1_icb_cmd_ready (s1_icb_cmd_ready),
      .s1_icb_rsp_rdata (s1_icb_rsp_rdata),
      .s1_icb_rsp_err   (s1_icb_rsp_err),
      .s1_icb_rsp_valid (s1_icb_rsp_valid),
      .s1_icb_rsp_ready (s1_icb_rsp_ready),
      .m_icb_cmd_addr   (m_icb_cmd_addr),
      .m_icb_cmd_read   (m_icb_cmd_read),
      .m_icb_cmd_wdata  (m_icb_cmd_wdata),
      .m_icb_cmd_wmask  (m_icb_cmd_wmask),
      .m_icb_cmd_valid  (m_icb_cmd_valid),
      .m_icb_cmd_ready  (m_icb_cmd_ready),
      .m_icb_rsp_rdata  (m_icb_rsp_rdata),
      .m_icb_rsp_err    (m_icb_rsp_err),
      .m_icb_rsp_valid  (m_icb_rsp_valid),
      .m_icb_rsp_ready  (m_icb_rsp_ready),
      .outstanding_cnt  (outstanding_cnt),
      .rsp_orphan       (rsp_orphan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       s0v;
      logic       s1v;
      logic       mrdy;
      logic       exp_mvalid;
      logic       exp_src;
      logic       exp_s0rdy;
      logic       exp_s1rdy;
      logic [4:0] exp_cnt;
   } vec_t;

   typedef struct {
      logic        src;
      logic [31:0] addr;
   } sb_t;

   int          checks = 0;
   int          errors = 0;
   vec_t        vecs [10];
   sb_t         sb [$];
   logic [31:0] slv_q [$];
   bit          slave_auto = 1'b0;
   logic [31:0] a0 = 32'h1000_0000;
   logic [31:0] a1 = 32'h2000_0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_payload();
      s0_icb_cmd_addr  = a0;
      s0_icb_cmd_wdata = ~a0;
      s1_icb_cmd_addr  = a1;
      s1_icb_cmd_wdata = a1 ^ 32'h5a5a_5a5a;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Called at the negedge: checks routed responses, then moves to just after the next rising edge.
   task automatic advance();
      bit          cmd_hs;
      bit          rsp_hs;
      logic [31:0] addr_seen;
      sb_t         e;
      cmd_hs    = m_icb_cmd_valid && m_icb_cmd_ready;
      rsp_hs    = m_icb_rsp_valid && m_icb_rsp_ready;
      addr_seen = m_icb_cmd_addr;
      if (slave_auto && m_icb_rsp_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: response with no expected entry at %0t", $time);
         end else begin
            e = sb[0];
            check("rsp_valid_s0", s0_icb_rsp_valid, e.src == 1'b0);
            check("rsp_valid_s1", s1_icb_rsp_valid, e.src == 1'b1);
            check("rsp_rdata", e.src ? s1_icb_rsp_rdata : s0_icb_rsp_rdata, e.addr);
            check("m_rsp_ready", m_icb_rsp_ready, 1);
            if (rsp_hs) void'(sb.pop_front());
         end
      end
      @(posedge clk);
      #1;
      if (slave_auto) begin
         if (rsp_hs && slv_q.size() > 0) void'(slv_q.pop_front());
         if (cmd_hs) slv_q.push_back(addr_seen);
         m_icb_rsp_valid = (slv_q.size() != 0);
         m_icb_rsp_rdata = (slv_q.size() != 0) ? slv_q[0] : 32'h0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      sb_t e;
      bit  drained;
      //           s0v   s1v   mrdy  mvld  src   s0rdy s1rdy cnt
      vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
      vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0};
      vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1};
      vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1};

      // Reset with every input active: outputs must stay quiet.
      resetn           = 1'b0;
      s0_icb_cmd_read  = 1'b1;
      s1_icb_cmd_read  = 1'b0;
      s0_icb_cmd_wmask = 4'hf;
      s1_icb_cmd_wmask = 4'h3;
      s0_icb_cmd_valid = 1'b1;
      s1_icb_cmd_valid = 1'b1;
      m_icb_cmd_ready  = 1'b1;
      m_icb_rsp_valid  = 1'b1;
      m_icb_rsp_rdata  = 32'h0;
      m_icb_rsp_err    = 1'b0;
      s0_icb_rsp_ready = 1'b1;
      s1_icb_rsp_ready = 1'b1;
      drive_payload();
      repeat (2) @(posedge clk);
      settle();
      check("rst_m_cmd_valid", m_icb_cmd_valid, 0);
      check("rst_s0_cmd_ready", s0_icb_cmd_ready, 0);
      check("rst_s1_cmd_ready", s1_icb_cmd_ready, 0);
      check("rst_m_rsp_ready", m_icb_rsp_ready, 0);
      check("rst_s0_rsp_valid", s0_icb_rsp_valid, 0);
      check("rst_s1_rsp_valid", s1_icb_rsp_valid, 0);
      check("rst_cnt", outstanding_cnt, 0);
      check("rst_orphan", rsp_orphan, 0);
      @(posedge clk);
      #1;
      resetn          = 1'b1;
      m_icb_rsp_valid = 1'b0;
      slave_auto      = 1'b1;

      // Round-robin and stall-lock table with the auto-responding slave.
      for (int i = 0; i < 10; i++) begin
         s0_icb_cmd_valid = vecs[i].s0v;
         s1_icb_cmd_valid = vecs[i].s1v;
         m_icb_cmd_ready  = vecs[i].mrdy;
         drive_payload();
         settle();
         check($sformatf("v%0d_m_valid", i), m_icb_cmd_valid, vecs[i].exp_mvalid);
         check($sformatf("v%0d_s0_ready", i), s0_icb_cmd_ready, vecs[i].exp_s0rdy);
         check($sformatf("v%0d_s1_ready", i), s1_icb_cmd_ready, vecs[i].exp_s1rdy);
         check($sformatf("v%0d_cnt", i), outstanding_cnt, vecs[i].exp_cnt);
         if (vecs[i].exp_mvalid) begin
            check($sformatf("v%0d_m_addr", i), m_icb_cmd_addr, vecs[i].exp_src ? a1 : a0);
            check($sformatf("v%0d_m_wdata", i), m_icb_cmd_wdata,
                  vecs[i].exp_src ? (a1 ^ 32'h5a5a_5a5a) : ~a0);
            check($sformatf("v%0d_m_read", i), m_icb_cmd_read, !vecs[i].exp_src);
            check($sformatf("v%0d_m_wmask", i), m_icb_cmd_wmask, vecs[i].exp_src ? 4'h3 : 4'hf);
         end
         if (vecs[i].exp_mvalid && vecs[i].mrdy) begin
            e.src  = vecs[i].exp_src;
            e.addr = vecs[i].exp_src ? a1 : a0;
            sb.push_back(e);
            if (vecs[i].exp_src) a1 += 32'd4;
            else                 a0 += 32'd4;
         end
         advance();
      end

      // Drain remaining responses within a bounded window.
      s0_icb_cmd_valid = 1'b0;
      s1_icb_cmd_valid = 1'b0;
      drained = 1'b0;
      for (int i = 0; i < 10; i++) begin
         settle();
         if (sb.size() == 0 && slv_q.size() == 0 && !m_icb_rsp_valid) begin
            drained = 1'b1;
            break;
         end
         advance();
      end
      check("drain_done", drained, 1);
      check("drain_sb_empty", sb.size(), 0);
      check("drain_cnt", outstanding_cnt, 0);
      @(posedge clk);
      #1;
      slave_auto      = 1'b0;
      m_icb_rsp_valid = 1'b0;

      // Fill the outstanding FIFO from s0 with no responses.
      s0_icb_cmd_valid = 1'b1;
      m_icb_cmd_ready  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_payload();
         settle();
         check($sformatf("fill%0d_s0_ready", i), s0_icb_cmd_ready, 1);
         check($sformatf("fill%0d_cnt", i), outstanding_cnt, i);
         a0 += 32'd4;
         advance();
      end
      drive_payload();
      settle();
      check("full_cnt", outstanding_cnt, 4);
      check("full_s0_ready", s0_icb_cmd_ready, 0);
      check("full_m_valid", m_icb_cmd_valid, 0);
      advance();
      m_icb_rsp_valid = 1'b1;
      m_icb_rsp_rdata = 32'hdead_0000;
      m_icb_rsp_err   = 1'b1;
      settle();
      check("full_pop_s0_rsp_valid", s0_icb_rsp_valid, 1);
      check("full_pop_s1_rsp_valid", s1_icb_rsp_valid, 0);
      check("full_pop_rdata", s0_icb_rsp_rdata, 32'hdead_0000);
      check("full_pop_err", s0_icb_rsp_err, 1);
      check("full_pop_s0_ready", s0_icb_cmd_ready, 0);
      advance();
      m_icb_rsp_valid = 1'b0;
      m_icb_rsp_err   = 1'b0;
      settle();
      check("after_pop_cnt", outstanding_cnt, 3);
      check("after_pop_s0_ready", s0_icb_cmd_ready, 1);
      a0 += 32'd4;
      advance();
      s0_icb_cmd_valid = 1'b0;
      settle();
      check("refill_cnt", outstanding_cnt, 4);

      // Head response held off by s0 for two cycles.
      advance();
      m_icb_rsp_valid  = 1'b1;
      s0_icb_rsp_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         check($sformatf("stall%0d_m_rsp_ready", i), m_icb_rsp_ready, 0);
         check($sformatf("stall%0d_s0_rsp_valid", i), s0_icb_rsp_valid, 1);
         check($sformatf("stall%0d_s1_rsp_valid", i), s1_icb_rsp_valid, 0);
         check($sformatf("stall%0d_cnt", i), outstanding_cnt, 4);
         advance();
      end
      s0_icb_rsp_ready = 1'b1;
      settle();
      check("unstall_m_rsp_ready", m_icb_rsp_ready, 1);
      advance();
      settle();
      check("unstall_cnt", outstanding_cnt, 3);
      for (int i = 0; i < 3; i++) advance();
      m_icb_rsp_valid = 1'b0;
      settle();
      check("stall_drain_cnt", outstanding_cnt, 0);

      // Orphan response with an empty FIFO.
      advance();
      m_icb_rsp_valid  = 1'b1;
      s0_icb_rsp_ready = 1'b0;
      s1_icb_rsp_ready = 1'b0;
      settle();
      check("orphan_m_rsp_ready", m_icb_rsp_ready, 1);
      check("orphan_s0_rsp_valid", s0_icb_rsp_valid, 0);
      check("orphan_s1_rsp_valid", s1_icb_rsp_valid, 0);
      check("orphan_pre", rsp_orphan, 0);
      advance();
      m_icb_rsp_valid  = 1'b0;
      s0_icb_rsp_ready = 1'b1;
      s1_icb_rsp_ready = 1'b1;
      settle();
      check("orphan_pulse", rsp_orphan, 1);
      check("orphan_cnt", outstanding_cnt, 0);
      advance();
      settle();
      check("orphan_clear", rsp_orphan, 0);

      // Reset with three commands outstanding, then the first tie after release.
      advance();
      s0_icb_cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_payload();
         settle();
         a0 += 32'd4;
         advance();
      end
      s0_icb_cmd_valid = 1'b0;
      settle();
      check("prereset_cnt", outstanding_cnt, 3);
      advance();
      s0_icb_cmd_valid = 1'b1;
      s1_icb_cmd_valid = 1'b1;
      m_icb_rsp_valid  = 1'b1;
      drive_payload();
      resetn = 1'b0;
      #2;
      check("mid_rst_cnt", outstanding_cnt, 0);
      check("mid_rst_m_cmd_valid", m_icb_cmd_valid, 0);
      check("mid_rst_s0_cmd_ready", s0_icb_cmd_ready, 0);
      check("mid_rst_s1_cmd_ready", s1_icb_cmd_ready, 0);
      check("mid_rst_m_rsp_ready", m_icb_rsp_ready, 0);
      check("mid_rst_s0_rsp_valid", s0_icb_rsp_valid, 0);
      check("mid_rst_s1_rsp_valid", s1_icb_rsp_valid, 0);
      @(posedge clk);
      #1;
      resetn          = 1'b1;
      m_icb_rsp_valid = 1'b0;
      settle();
      check("post_rst_m_valid", m_icb_cmd_valid, 1);
      check("post_rst_m_addr", m_icb_cmd_addr, a0);
      check("post_rst_s0_ready", s0_icb_cmd_ready, 1);
      check("post_rst_s1_ready", s1_icb_cmd_ready, 0);
      advance();
      s0_icb_cmd_valid = 1'b0;
      s1_icb_cmd_valid = 1'b0;
      settle();
      check("post_rst_cnt", outstanding_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
